// File: rtl/if_prefetch_rv32_if.sv
// Fetch-stage bundle: ICache request/response, redirect, and Decode-side
// instruction stream. The fetch unit takes the master side.
interface if_prefetch_rv32_if #(
    parameter int XLEN = 32
);
    logic            oIREQ;
    logic [XLEN-1:0] oIADDR;
    logic            iIGNT;
    logic            iIRVALID;
    logic [31:0]     iIRDATA;
    logic            iBRANCH;
    logic [XLEN-1:0] iBranchADDR;
    logic            iStallD;
    logic            oINSTR_VALID;
    logic [31:0]     oINSTR;
    logic [XLEN-1:0] oINSTR_PC;
    logic            oERR;

    modport master (
        output oIREQ, oIADDR, oINSTR_VALID, oINSTR, oINSTR_PC, oERR,
        input  iIGNT, iIRVALID, iIRDATA, iBRANCH, iBranchADDR, iStallD
    );

    modport slave (
        input  oIREQ, oIADDR, oINSTR_VALID, oINSTR, oINSTR_PC, oERR,
        output iIGNT, iIRVALID, iIRDATA, iBRANCH, iBranchADDR, iStallD
    );
endinterface

// File: rtl/if_prefetch_rv32.sv
// Instruction fetch with a credit-limited prefetch queue; redirects flush
// the queue and drop responses still in flight.
module if_prefetch_rv32 #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 4,
    parameter int              CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input logic iCLK,
    input logic iRST,
    if_prefetch_rv32_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [31:0]      data_q [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_q   [FIFO_DEPTH];

    logic             grant, rsp_ok, push, pop;
    logic [CNT_W:0]   inflight;
    logic [XLEN-1:0]  br_tgt;
    logic             unused_br;

    assign br_tgt    = {bus.iBranchADDR[XLEN-1:2], 2'b00};
    assign unused_br = ^bus.iBranchADDR[1:0];

    // Queue entries plus in-flight requests bound the credit.
    assign inflight  = {1'b0, cnt_q} + {1'b0, out_q};
    assign bus.oIREQ = ~iRST & ~bus.iBRANCH &
                       (inflight < (CNT_W + 1)'(FIFO_DEPTH));
    assign bus.oIADDR = fetch_pc_q;

    assign grant  = bus.oIREQ & bus.iIGNT;
    assign rsp_ok = bus.iIRVALID & (out_q != '0);
    assign push   = rsp_ok & ~bus.iBRANCH & (drop_q == '0);
    assign pop    = (cnt_q != '0) & ~bus.iStallD & ~bus.iBRANCH;

    assign bus.oINSTR_VALID = (cnt_q != '0);
    assign bus.oINSTR       = data_q[rd_q];
    assign bus.oINSTR_PC    = pc_q[rd_q];
    assign bus.oERR         = err_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        out_d      = out_q + CNT_W'(grant) - CNT_W'(rsp_ok);
        err_d      = err_q | (bus.iIRVALID & (out_q == '0));
        if (bus.iBRANCH) begin
            // No grant is possible here, so out_d already excludes
            // a response arriving this cycle.
            fetch_pc_d = br_tgt;
            resp_pc_d  = br_tgt;
            cnt_d      = '0;
            rd_d       = '0;
            wr_d       = '0;
            drop_d     = out_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_ok && drop_q != '0) drop_d = drop_q - 1'b1;
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_d      = wr_q + 1'b1;
            end
            if (pop) rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fetch_pc_q <= RESET_VECTOR;
            resp_pc_q  <= RESET_VECTOR;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= RESET_VECTOR;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            if (push) begin
                data_q[wr_q] <= bus.iIRDATA;
                pc_q[wr_q]   <= resp_pc_q;
            end
        end
    end
endmodule

// File: doc/if_prefetch_rv32.md
Name: if_prefetch_rv32

Overview:
Parametrised instruction-fetch stage with a prefetch queue. It issues in-order fetch requests to the ICache under a credit limit and buffers returned instructions together with their PCs. It presents them to Decode through a valid/stall interface. A taken branch redirects fetch, flushes the queue and discards responses still in flight. It sits between the ICache port and the IF/ID boundary, replacing the single-register PC fetch.

Parameters:
XLEN, 32, width of PC and addresses
RESET_VECTOR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
FIFO_DEPTH, 4, prefetch queue entries; power of 2, at least 2
CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy and outstanding counters

Ports:
iCLK  in  1  clock, rising edge
iRST  in  1  asynchronous reset, active-high
oIREQ  out  1  fetch request valid
oIADDR  out  XLEN  fetch address, word aligned
iIGNT  in  1  ICache accepts the request this cycle; meaningful only while oIREQ=1
iIRVALID  in  1  response valid; responses return in order, 1 or more cycles after grant
iIRDATA  in  32  response instruction word
iBRANCH  in  1  taken branch or jump: redirect fetch
iBranchADDR  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
iStallD  in  1  Decode cannot accept an instruction this cycle
oINSTR_VALID  out  1  queue head valid
oINSTR  out  32  queue head instruction
oINSTR_PC  out  XLEN  PC of the queue head
oERR  out  1  sticky protocol error: response received with outstanding = 0

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): all state is cleared.
  - fetch_pc = resp_pc = RESET_VECTOR.
  - Queue is empty; outstanding = 0; drop_cnt = 0; oERR = 0.
  - Outputs during reset: oIREQ = 0, oINSTR_VALID = 0, oIADDR = RESET_VECTOR, oINSTR = 0, oINSTR_PC = RESET_VECTOR.
- Request generation (combinational):
  - oIREQ = ~iBRANCH & (count + outstanding < FIFO_DEPTH).
  - oIADDR = fetch_pc.
  - A grant (oIREQ & iIGNT) does: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1.
- Responses: every iIRVALID decrements outstanding.
  - A simultaneous grant and response leaves outstanding unchanged.
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise {resp_pc, iIRDATA} is pushed into the queue and resp_pc += 4.
- Credit rule: a push can never overflow the queue, because entries plus in-flight requests never exceed FIFO_DEPTH.
- Queue output: registered.
  - A response at cycle N appears on oINSTR_VALID/oINSTR/oINSTR_PC at cycle N+1. There is no bypass.
  - Pop when oINSTR_VALID & ~iStallD & ~iBRANCH.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Branch (iBRANCH=1 at cycle N; takes priority over every other event that cycle):
  - The queue is flushed (count = 0).
  - fetch_pc = resp_pc = {iBranchADDR[XLEN-1:2], 2'b00}.
  - drop_cnt = outstanding minus (1 if iIRVALID at N), floored at 0. A response arriving at N is discarded.
  - oIREQ = 0 at N, so no grant can occur.
  - First request to the target is at N+1 (subject to credit; credit is normally free after the flush).
  - Branch on consecutive cycles: the last one wins. drop_cnt is recomputed each time from the current outstanding.
- While stalled (iStallD=1): the queue holds. Fetch continues until credit is exhausted; oIREQ then drops to 0.
- Protocol error: iIRVALID with outstanding = 0 sets oERR (sticky until reset). The response is ignored and counters do not underflow.
- Steady state with single-cycle grant and 1-cycle response latency: one instruction per cycle.

Test Plan:
1. Reset release, iIGNT=1 always, 1-cycle response latency, iStallD=0 → oIADDR = 0x0, 0x4, 0x8… on consecutive cycles. First oINSTR_VALID 2 cycles after the first grant, with oINSTR_PC = 0x0. One instruction per cycle thereafter.
2. FIFO_DEPTH=4, iStallD=1 held → exactly 4 grants, then oIREQ=0. Queue holds PCs 0x0 to 0xC. Release stall → pops in order 0x0, 0x4, 0x8, 0xC, with fetch resuming the cycle after the first pop.
3. Response latency 3, two requests outstanding, iBRANCH with iBranchADDR=0x103 → oIREQ=0 that cycle; next cycle oIADDR=0x100. Both stale responses are dropped. First oINSTR_PC = 0x100.
4. Branch coincident with a response and with iStallD=0 and a valid head → no pop; the response is dropped and the queue is empty next cycle. Back-to-back branches to 0x200 then 0x300 → fetch resumes at 0x300.
5. fetch_pc = 0xFFFF_FFFC granted → next oIADDR = 0x0000_0000, and oINSTR_PC wraps the same way.
6. Assert iRST mid-transfer with 2 outstanding → all outputs take their reset values immediately. After release, the first fetch is at RESET_VECTOR. Inject iIRVALID with nothing outstanding → oERR=1 and stays set until reset.
